// File: rtl/pipe_stage_reg.sv
// Reusable pipeline-stage register: valid/ready handshake, optional 2-entry skid,
// flush, bubble payload on empty and a saturating starvation counter.
module pipe_stage_reg #(
  parameter int unsigned           WIDTH        = 32,
  parameter int unsigned           SKID         = 1,
  parameter logic [WIDTH-1:0]      BUBBLE_VALUE = '0,
  parameter int unsigned           CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] bubble_cnt
);

  localparam bit                   USE_SKID = (SKID != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  // Occupancy doubles as the state encoding.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     main_q, main_d;
  logic [WIDTH-1:0]     skid_q, skid_d;
  logic                 ready_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 push, pop;

  assign out_valid  = (state_q != ST_EMPTY);
  assign out_data   = main_q;
  assign occupancy  = state_q;
  assign bubble_cnt = cnt_q;
  assign in_ready   = USE_SKID ? ready_q : (!out_valid || out_ready);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Next-state and payload steering; main_q is refilled with the bubble whenever the stage empties.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE_VALUE;
      skid_d  = BUBBLE_VALUE;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (push && pop) begin
            main_d  = in_data;
          end else if (pop) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VALUE;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE_VALUE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_VALUE;
          skid_d  = BUBBLE_VALUE;
        end
      endcase
    end
  end

  // Starvation counter sees pre-edge values, flush cycles included.
  always_comb begin
    cnt_d = cnt_q;
    if (out_ready && !out_valid && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE_VALUE;
      skid_q  <= BUBBLE_VALUE;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != ST_TWO);
      cnt_q   <= cnt_d;
    end
  end

endmodule
